// File: rtl/fp_div_seq_if.sv
// Shared FP types and the request/divider/result bundle for the fp_div_seq sequencer.
// slave = sequencer view, master = requester/divider/consumer view.
package fp_div_pkg;
  typedef enum logic [1:0] {FP32, FP64, FP16, BF16} fp_format_e;
  typedef enum logic [2:0] {RNE, RTZ, RDN, RUP, RMM} roundmode_e;

  // Sized for the widest format; mant carries guard/round/sticky in its low bits.
  typedef struct packed {
    logic               sign;
    logic signed [12:0] exp;
    logic [55:0]        mant;
  } uround_res_t;

  function automatic int fp_width(input fp_format_e fmt);
    case (fmt)
      FP64:    return 64;
      FP16:    return 16;
      BF16:    return 16;
      default: return 32;
    endcase
  endfunction
endpackage

interface fp_div_seq_if import fp_div_pkg::*; #(parameter int FP_WIDTH = 32);
  logic                in_valid_i;
  logic                in_ready_o;
  logic [FP_WIDTH-1:0] a_i;
  logic [FP_WIDTH-1:0] b_i;
  roundmode_e          rnd_i;
  logic [FP_WIDTH-1:0] div_a_o;
  logic [FP_WIDTH-1:0] div_b_o;
  roundmode_e          div_rnd_o;
  logic                div_start_o;
  logic                div_done_i;
  uround_res_t         div_urnd_i;
  logic                out_valid_o;
  logic                out_ready_i;
  uround_res_t         out_urnd_o;
  roundmode_e          out_rnd_o;
  logic                timeout_o;

  modport slave (
    input  in_valid_i, a_i, b_i, rnd_i, div_done_i, div_urnd_i, out_ready_i,
    output in_ready_o, div_a_o, div_b_o, div_rnd_o, div_start_o,
           out_valid_o, out_urnd_o, out_rnd_o, timeout_o
  );

  modport master (
    output in_valid_i, a_i, b_i, rnd_i, div_done_i, div_urnd_i, out_ready_i,
    input  in_ready_o, div_a_o, div_b_o, div_rnd_o, div_start_o,
           out_valid_o, out_urnd_o, out_rnd_o, timeout_o
  );
endinterface

// File: rtl/fp_div_seq.sv
// Sequencer around an iterative FP divider: accept, start pulse, wait done, hold result.
// Optional BUSY watchdog enabled by defining FP_DIV_SEQ_TIMEOUT_EN.
module fp_div_seq import fp_div_pkg::*; #(
  parameter fp_format_e FP_FORMAT      = FP32,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic         clk_i,
  input  logic         reset_i,
  fp_div_seq_if.slave  bus
);
  localparam int FP_WIDTH = fp_width(FP_FORMAT);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fp_div_seq: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, START, BUSY, HOLD} state_e;

  state_e              state;
  logic [FP_WIDTH-1:0] a_q, b_q;
  roundmode_e          rnd_q, out_rnd_q;
  uround_res_t         urnd_q;
  logic                start_q, valid_q;
  logic                in_ready;

`ifdef FP_DIV_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            to_q;
`endif

  // HOLD can hand off to a new request in the same cycle it drains.
  assign in_ready = (state == IDLE) || (state == HOLD && bus.out_ready_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      rnd_q     <= RNE;
      out_rnd_q <= RNE;
      urnd_q    <= '0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
`ifdef FP_DIV_SEQ_TIMEOUT_EN
      wd_cnt    <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid_i) begin
            a_q     <= bus.a_i;
            b_q     <= bus.b_i;
            rnd_q   <= bus.rnd_i;
            start_q <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          state <= BUSY;
`ifdef FP_DIV_SEQ_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        BUSY: begin
          if (bus.div_done_i) begin
            urnd_q    <= bus.div_urnd_i;
            out_rnd_q <= rnd_q;
            valid_q   <= 1'b1;
            state     <= HOLD;
          end
`ifdef FP_DIV_SEQ_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            to_q  <= 1'b1;
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end
        HOLD: begin
          if (bus.out_ready_i) begin
            valid_q <= 1'b0;
            if (bus.in_valid_i) begin
              a_q     <= bus.a_i;
              b_q     <= bus.b_i;
              rnd_q   <= bus.rnd_i;
              start_q <= 1'b1;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.div_a_o     = a_q;
  assign bus.div_b_o     = b_q;
  assign bus.div_rnd_o   = rnd_q;
  assign bus.div_start_o = start_q;
  assign bus.out_valid_o = valid_q;
  assign bus.out_urnd_o  = urnd_q;
  assign bus.out_rnd_o   = out_rnd_q;
`ifdef FP_DIV_SEQ_TIMEOUT_EN
  assign bus.timeout_o   = to_q;
`else
  assign bus.timeout_o   = 1'b0;
`endif
endmodule
